// File: rtl/frida_conv_seq_if.sv
// Control/config/status bundle between the FRIDA core and the on-chip
// conversion sequencer. The sequencer is the slave; the core side is the master.
interface frida_conv_seq_if #(
    parameter int CNT_W   = 8,
    parameter int NUM_ADC = 16,
    parameter int SEL_W   = 4,
    parameter int NCONV_W = 8
);
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   cfg_t_init;
    logic [CNT_W-1:0]   cfg_t_samp;
    logic [CNT_W-1:0]   cfg_t_cmp;
    logic [CNT_W-1:0]   cfg_t_logic;
    logic [NCONV_W-1:0] cfg_nconv;
    logic [NUM_ADC-1:0] cfg_adc_mask;
    logic               seq_init;
    logic               seq_samp;
    logic               seq_cmp;
    logic               seq_logic;
    logic [SEL_W-1:0]   mux_sel;
    logic               busy;
    logic               done;
    logic [NCONV_W-1:0] conv_cnt;

    modport master (
        output start, abort, cfg_t_init, cfg_t_samp, cfg_t_cmp, cfg_t_logic,
               cfg_nconv, cfg_adc_mask,
        input  seq_init, seq_samp, seq_cmp, seq_logic, mux_sel, busy, done,
               conv_cnt
    );

    modport slave (
        input  start, abort, cfg_t_init, cfg_t_samp, cfg_t_cmp, cfg_t_logic,
               cfg_nconv, cfg_adc_mask,
        output seq_init, seq_samp, seq_cmp, seq_logic, mux_sel, busy, done,
               conv_cnt
    );
endinterface

// File: rtl/frida_conv_seq.sv
// FRIDA SAR conversion sequencer: generates INIT/SAMP/CMP/LOGIC strobes with
// programmable phase lengths and scans the comparator mux over enabled ADCs.
module frida_conv_seq #(
    parameter int NBITS   = 8,
    parameter int CNT_W   = 8,
    parameter int NUM_ADC = 16,
    parameter int SEL_W   = 4,
    parameter int NCONV_W = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    frida_conv_seq_if.slave bus
);
    localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {IDLE, INIT, SAMP, CMP, LOGIC, NEXT, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   ph_cnt, ph_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [NCONV_W-1:0] conv_cnt_q, conv_nxt;
    logic [SEL_W-1:0]   mux_sel_q, sel_nxt;
    logic               latch_cfg;

    // Run configuration, frozen when a start is accepted.
    logic [CNT_W-1:0]   t_init_q, t_samp_q, t_cmp_q, t_logic_q;
    logic [NCONV_W-1:0] nconv_q;
    logic [NUM_ADC-1:0] mask_q;

    logic seq_init_q, seq_samp_q, seq_cmp_q, seq_logic_q, busy_q, done_q;

    // Last cycle of a phase; a programmed length of 0 behaves as 1.
    function automatic logic phase_end(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] len);
        return (len == '0) || (cnt == len - CNT_W'(1));
    endfunction

    function automatic logic [SEL_W-1:0] lowest_sel(input logic [NUM_ADC-1:0] mask);
        logic             found = 1'b0;
        logic [SEL_W-1:0] res   = '0;
        for (int i = 0; i < NUM_ADC; i++) begin
            if (!found && mask[i]) begin
                res   = SEL_W'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Next enabled ADC above cur, wrapping; a lone bit maps back onto itself.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0]   cur,
                                                  input logic [NUM_ADC-1:0] mask);
        logic             found = 1'b0;
        logic [SEL_W-1:0] res   = cur;
        int               idx;
        for (int i = 1; i < NUM_ADC; i++) begin
            idx = (int'(cur) + i) % NUM_ADC;
            if (!found && mask[idx]) begin
                res   = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Next-state, phase/bit counters, scan position and conversion count.
    always_comb begin
        // NOTE: every variable gets a default first so no path holds a stale value (no latch).
        state_nxt = state;
        ph_nxt    = ph_cnt;
        bit_nxt   = bit_cnt;
        conv_nxt  = conv_cnt_q;
        sel_nxt   = mux_sel_q;
        latch_cfg = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && (bus.cfg_adc_mask != '0)) begin
                    latch_cfg = 1'b1;
                    sel_nxt   = lowest_sel(bus.cfg_adc_mask);
                    conv_nxt  = '0;
                    ph_nxt    = '0;
                    state_nxt = INIT;
                end
            end
            INIT: begin
                if (phase_end(ph_cnt, t_init_q)) begin
                    ph_nxt    = '0;
                    state_nxt = SAMP;
                end else begin
                    ph_nxt = ph_cnt + CNT_W'(1);
                end
            end
            SAMP: begin
                if (phase_end(ph_cnt, t_samp_q)) begin
                    ph_nxt    = '0;
                    bit_nxt   = '0;
                    state_nxt = CMP;
                end else begin
                    ph_nxt = ph_cnt + CNT_W'(1);
                end
            end
            CMP: begin
                if (phase_end(ph_cnt, t_cmp_q)) begin
                    ph_nxt    = '0;
                    state_nxt = LOGIC;
                end else begin
                    ph_nxt = ph_cnt + CNT_W'(1);
                end
            end
            LOGIC: begin
                if (phase_end(ph_cnt, t_logic_q)) begin
                    ph_nxt = '0;
                    if (bit_cnt != BIT_W'(NBITS - 1)) begin
                        bit_nxt   = bit_cnt + BIT_W'(1);
                        state_nxt = CMP;
                    end else begin
                        conv_nxt = conv_cnt_q + NCONV_W'(1);
                        if ((nconv_q != '0) && (conv_nxt == nconv_q)) begin
                            state_nxt = DONE;
                        end else begin
                            sel_nxt   = next_sel(mux_sel_q, mask_q);
                            state_nxt = NEXT;
                        end
                    end
                end else begin
                    ph_nxt = ph_cnt + CNT_W'(1);
                end
            end
            NEXT:    state_nxt = INIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start.
        if (bus.abort) begin
            state_nxt = IDLE;
            conv_nxt  = conv_cnt_q;
            sel_nxt   = mux_sel_q;
            latch_cfg = 1'b0;
        end
    end

    // State, counters, latched config and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_b) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            bit_cnt     <= '0;
            conv_cnt_q  <= '0;
            mux_sel_q   <= '0;
            t_init_q    <= '0;
            t_samp_q    <= '0;
            t_cmp_q     <= '0;
            t_logic_q   <= '0;
            nconv_q     <= '0;
            mask_q      <= '0;
            seq_init_q  <= 1'b0;
            seq_samp_q  <= 1'b0;
            seq_cmp_q   <= 1'b0;
            seq_logic_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ph_cnt     <= ph_nxt;
            bit_cnt    <= bit_nxt;
            conv_cnt_q <= conv_nxt;
            mux_sel_q  <= sel_nxt;
            if (latch_cfg) begin
                t_init_q  <= bus.cfg_t_init;
                t_samp_q  <= bus.cfg_t_samp;
                t_cmp_q   <= bus.cfg_t_cmp;
                t_logic_q <= bus.cfg_t_logic;
                nconv_q   <= bus.cfg_nconv;
                mask_q    <= bus.cfg_adc_mask;
            end
            seq_init_q  <= (state_nxt == INIT);
            seq_samp_q  <= (state_nxt == SAMP);
            seq_cmp_q   <= (state_nxt == CMP);
            seq_logic_q <= (state_nxt == LOGIC);
            busy_q      <= (state_nxt inside {INIT, SAMP, CMP, LOGIC, NEXT});
            done_q      <= (state_nxt == DONE);
        end
    end

    assign bus.seq_init  = seq_init_q;
    assign bus.seq_samp  = seq_samp_q;
    assign bus.seq_cmp   = seq_cmp_q;
    assign bus.seq_logic = seq_logic_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.conv_cnt  = conv_cnt_q;
endmodule

// File: tb/tb_frida_conv_seq.sv
// Directed testbench for frida_conv_seq: phase timing, mux scanning, abort,
// ignored starts, config latching and mid-run reset.
`timescale 1ns/1ps
module tb_frida_conv_seq;
    logic clk = 1'b0;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    frida_conv_seq_if #(.CNT_W(8), .NUM_ADC(16), .SEL_W(4), .NCONV_W(8)) bus ();

    frida_conv_seq #(.NBITS(8), .CNT_W(8), .NUM_ADC(16), .SEL_W(4), .NCONV_W(8)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {mux_sel, init, samp, cmp, logic, busy, done}
    function automatic logic [9:0] obs();
        return {bus.mux_sel, bus.seq_init, bus.seq_samp, bus.seq_cmp,
                bus.seq_logic, bus.busy, bus.done};
    endfunction

    // {init, samp, cmp, logic, busy, done}
    function automatic logic [5:0] obs_ctl();
        return {bus.seq_init, bus.seq_samp, bus.seq_cmp, bus.seq_logic,
                bus.busy, bus.done};
    endfunction

    task automatic set_cfg(input int ti, input int ts, input int tc, input int tl,
                           input int nconv, input logic [15:0] mask);
        bus.cfg_t_init   = 8'(ti);
        bus.cfg_t_samp   = 8'(ts);
        bus.cfg_t_cmp    = 8'(tc);
        bus.cfg_t_logic  = 8'(tl);
        bus.cfg_nconv    = 8'(nconv);
        bus.cfg_adc_mask = mask;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Checks one conversion cycle by cycle, starting in its first INIT cycle
    // and ending in its last LOGIC cycle. At cycle 'poke' a stray start pulse
    // is issued and cfg_t_cmp/cfg_t_init are changed; neither may disturb the run.
    task automatic expect_conv(input int ti, input int ts, input int tc, input int tl,
                               input int sel, input int poke, input string tag);
        int li = (ti == 0) ? 1 : ti;
        int ls = (ts == 0) ? 1 : ts;
        int lc = (tc == 0) ? 1 : tc;
        int ll = (tl == 0) ? 1 : tl;
        int total = li + ls + 8 * (lc + ll);
        logic [3:0] ph;
        for (int n = 0; n < total; n++) begin
            if (n > 0) begin
                step();
                bus.start = 1'b0;
            end
            if (n < li)                                ph = 4'b1000;
            else if (n < li + ls)                      ph = 4'b0100;
            else if (((n - li - ls) % (lc + ll)) < lc) ph = 4'b0010;
            else                                       ph = 4'b0001;
            check($sformatf("%s cyc%0d", tag, n + 1), obs(), {4'(sel), ph, 1'b1, 1'b0});
            if (n == poke) begin
                bus.start      = 1'b1;
                bus.cfg_t_cmp  = 8'd5;
                bus.cfg_t_init = 8'd7;
            end
        end
    endtask

    initial begin
        rst_b = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(2, 3, 1, 1, 1, 16'h0001);
        step();
        step();
        check("reset outputs", obs(), 10'h000);
        check("reset conv_cnt", bus.conv_cnt, 8'd0);
        rst_b = 1'b1;
        step();

        // Basic run: INIT 1-2, SAMP 3-5, CMP/LOGIC 6-21, done at 22.
        pulse_start();
        expect_conv(2, 3, 1, 1, 0, -1, "t1");
        step();
        check("t1 done", obs(), {4'd0, 4'b0000, 1'b0, 1'b1});
        check("t1 conv_cnt", bus.conv_cnt, 8'd1);
        step();
        check("t1 idle after done", obs(), 10'h000);

        // Scan over mask 0x8421, five conversions: 0,5,10,15,0.
        set_cfg(1, 1, 1, 1, 5, 16'h8421);
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            expect_conv(1, 1, 1, 1, (k * 5) % 20, -1, $sformatf("t2 conv%0d", k));
            step();
            if (k < 4) begin
                check($sformatf("t2 next%0d", k), obs_ctl(), 6'b0000_10);
                step();
            end
        end
        check("t2 done", obs(), {4'd0, 4'b0000, 1'b0, 1'b1});
        check("t2 conv_cnt", bus.conv_cnt, 8'd5);
        step();
        check("t2 single done pulse", obs_ctl(), 6'b0);

        // Continuous run on mask 0x0003, abort during third SAMP.
        set_cfg(1, 1, 1, 1, 0, 16'h0003);
        pulse_start();
        expect_conv(1, 1, 1, 1, 0, -1, "t4 conv0");
        step();
        check("t4 next0", obs_ctl(), 6'b0000_10);
        step();
        expect_conv(1, 1, 1, 1, 1, -1, "t4 conv1");
        step();
        check("t4 next1", obs_ctl(), 6'b0000_10);
        check("t4 conv_cnt mid", bus.conv_cnt, 8'd2);
        step();
        check("t4 conv2 init", obs(), {4'd0, 4'b1000, 1'b1, 1'b0});
        step();
        check("t4 conv2 samp", obs(), {4'd0, 4'b0100, 1'b1, 1'b0});
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4 after abort", obs(), 10'h000);
        check("t4 conv_cnt held", bus.conv_cnt, 8'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4 no done %0d", i), obs(), 10'h000);
        end

        // Start with empty mask is ignored; start+abort together is dropped.
        set_cfg(1, 1, 1, 1, 1, 16'h0000);
        pulse_start();
        check("t5 empty mask", obs(), 10'h000);
        step();
        check("t5 empty mask later", obs(), 10'h000);
        check("t5 conv_cnt kept", bus.conv_cnt, 8'd2);
        set_cfg(1, 1, 1, 1, 1, 16'h0001);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("t5 start+abort", obs(), 10'h000);
        step();
        check("t5 start+abort later", obs(), 10'h000);

        // Stray start and cfg changes mid-run leave the run untouched.
        set_cfg(1, 2, 1, 1, 1, 16'h0002);
        pulse_start();
        expect_conv(1, 2, 1, 1, 1, 4, "t6");
        step();
        check("t6 done", obs(), {4'd1, 4'b0000, 1'b0, 1'b1});
        check("t6 conv_cnt", bus.conv_cnt, 8'd1);
        step();
        check("t6 idle", obs(), {4'd1, 6'b0});

        // Single-bit mask keeps mux_sel; reset during CMP clears everything.
        set_cfg(1, 1, 1, 1, 3, 16'h0004);
        pulse_start();
        expect_conv(1, 1, 1, 1, 2, -1, "t7 conv0");
        step();
        check("t7 next", obs(), {4'd2, 4'b0000, 1'b1, 1'b0});
        step();
        check("t7 init", obs(), {4'd2, 4'b1000, 1'b1, 1'b0});
        step();
        step();
        check("t7 cmp", obs(), {4'd2, 4'b0010, 1'b1, 1'b0});
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        check("t7 reset outputs", obs(), 10'h000);
        check("t7 reset conv_cnt", bus.conv_cnt, 8'd0);
        step();
        check("t7 stays idle", obs(), 10'h000);

        // Zero phase lengths behave as 1: 18-cycle conversion.
        set_cfg(0, 0, 0, 0, 1, 16'h0010);
        pulse_start();
        expect_conv(0, 0, 0, 0, 4, -1, "t3");
        step();
        check("t3 done", obs(), {4'd4, 4'b0000, 1'b0, 1'b1});
        check("t3 conv_cnt", bus.conv_cnt, 8'd1);
        step();
        check("t3 idle", obs_ctl(), 6'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
